// File: rtl/adc_dac_spi_pkg.sv
// adc_dac_spi_pkg: register map, command prefix, sequencer states and ADC-to-DAC code conversion
package adc_dac_spi_pkg;
   localparam logic [7:0] ADR_TX     = 8'h00;
   localparam logic [7:0] ADR_CTRL   = 8'h10;
   localparam logic [7:0] ADR_DIVIDE = 8'h14;
   localparam logic [7:0] ADR_SS     = 8'h18;
   localparam logic [1:0] WR_PREFIX  = 2'b01;
   typedef enum logic [2:0] {INIT, SCAN, POP, LATCH, WR_TX, WR_GO} state_e;
   // Keep the top dac_w bits of the sample and flip their MSB: two's complement to offset binary.
   function automatic logic [31:0] offset_bin(input logic [31:0] adc, input int adc_w, input int dac_w);
      logic [31:0] code;
      code = (adc >> (adc_w - dac_w)) & ((32'h1 << dac_w) - 32'h1);
      return code ^ (32'h1 << (dac_w - 1));
   endfunction
endpackage

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: one register write as a setup cycle followed by two strobe cycles
module spi_reg_writer
   import adc_dac_spi_pkg::*;
#(
   parameter logic [7:0]  RST_ADR = ADR_DIVIDE,
   parameter logic [31:0] RST_DAT = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [7:0]  adr_i,
   input  logic [31:0] dat_i,
   output logic [7:0]  adr,
   output logic [33:0] cmd_word,
   output logic        cmd_stb,
   output logic        done
);
   logic [1:0]  ph_q, ph_d;
   logic [7:0]  adr_q, adr_d;
   logic [33:0] cmd_q, cmd_d;
   logic        stb_q, stb_d;
   // Phase 1 is setup, 2 and 3 strobe, 0 idle; reset lands in the setup of the first write.
   always_comb begin
      ph_d  = req ? 2'd1 : ph_q == 2'd0 ? 2'd0 : ph_q + 2'd1;
      stb_d = ph_d[1];
      adr_d = req ? adr_i : adr_q;
      cmd_d = req ? {WR_PREFIX, dat_i} : cmd_q;
   end
   always_ff @(posedge clk)
      if (rst) begin
         ph_q  <= 2'd1;
         stb_q <= 1'b0;
         adr_q <= RST_ADR;
         cmd_q <= {WR_PREFIX, RST_DAT};
      end else begin
         ph_q  <= ph_d;
         stb_q <= stb_d;
         adr_q <= adr_d;
         cmd_q <= cmd_d;
      end
   assign done     = ph_q == 2'd3;
   assign adr      = adr_q;
   assign cmd_word = cmd_q;
   assign cmd_stb  = stb_q;
endmodule

// File: rtl/adc_dac_spi_sequencer.sv
// adc_dac_spi_sequencer: programs NCH SPI masters, then round-robins ADC FIFOs into DAC TX/GO writes
module adc_dac_spi_sequencer
   import adc_dac_spi_pkg::*;
#(
   parameter int          ADC_W      = 16,
   parameter int          DAC_W      = 14,
   parameter int          NCH        = 2,
   parameter logic [31:0] DIVIDE_VAL = 32'h0,
   parameter logic [31:0] CTRL_VAL   = 32'h3010,
   parameter int          GO_BIT     = 8,
   parameter logic [31:0] SS_VAL     = 32'h1,
   localparam int         CW         = NCH > 1 ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [NCH-1:0]     empty,
   input  logic [NCH*ADC_W-1:0] adc_dat_i,
   input  logic [NCH-1:0]     int_o,
   output logic [NCH-1:0]     rd_en,
   output logic [CW-1:0]      ch_sel,
   output logic [7:0]         adr,
   output logic [33:0]        cmd_word,
   output logic               cmd_stb,
   output logic [NCH-1:0]     busy,
   output logic               init_done
);
   localparam logic [31:0] GO_VAL = CTRL_VAL | (32'h1 << GO_BIT);
   state_e         state_q, state_d;
   logic [CW-1:0]  ptr_q, ptr_d, cur_q, cur_d, ich_q, ich_d, ch_sel_q, ch_sel_d, sel;
   logic [1:0]     ireg_q, ireg_d;
   logic [NCH-1:0] rd_en_q, rd_en_d, busy_q, busy_d, avail;
   logic           init_done_q, init_done_d, req, done, found;
   logic [7:0]     req_adr;
   logic [31:0]    req_dat;
   int             k;
   assign avail = ~empty & ~busy_q;
   always_comb begin
      sel   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NCH; i++) begin
         k = int'(ptr_q) + i;
         if (k >= NCH) k = k - NCH;
         if (!found && avail[k]) begin
            found = 1'b1;
            sel   = CW'(k);
         end
      end
   end
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_d       = cur_q;
      ich_d       = ich_q;
      ireg_d      = ireg_q;
      ch_sel_d    = ch_sel_q;
      rd_en_d     = '0;
      init_done_d = init_done_q;
      busy_d      = busy_q & ~int_o;
      req         = 1'b0;
      req_adr     = ADR_TX;
      req_dat     = '0;
      case (state_q)
         INIT: if (done) begin
            if (ireg_q == 2'd2 && ich_q == CW'(NCH - 1)) begin
               state_d     = SCAN;
               init_done_d = 1'b1;
            end else begin
               req      = 1'b1;
               ireg_d   = ireg_q == 2'd2 ? 2'd0 : ireg_q + 2'd1;
               ich_d    = ireg_q == 2'd2 ? ich_q + 1'b1 : ich_q;
               ch_sel_d = ich_d;
               req_adr  = ireg_d == 2'd1 ? ADR_CTRL : ireg_d == 2'd2 ? ADR_SS : ADR_DIVIDE;
               req_dat  = ireg_d == 2'd1 ? CTRL_VAL : ireg_d == 2'd2 ? SS_VAL : DIVIDE_VAL;
            end
         end
         SCAN: if (found && enable) begin
            state_d      = POP;
            cur_d        = sel;
            rd_en_d[sel] = 1'b1;
         end
         POP: state_d = LATCH;
         LATCH: begin
            req      = 1'b1;
            ch_sel_d = cur_q;
            req_dat  = offset_bin(32'(adc_dat_i[int'(cur_q)*ADC_W +: ADC_W]), ADC_W, DAC_W);
            state_d  = WR_TX;
         end
         WR_TX: if (done) begin
            req     = 1'b1;
            req_adr = ADR_CTRL;
            req_dat = GO_VAL;
            state_d = WR_GO;
         end
         WR_GO: if (done) begin
            busy_d[cur_q] = 1'b1;
            ptr_d         = cur_q == CW'(NCH - 1) ? '0 : cur_q + 1'b1;
            state_d       = SCAN;
         end
         default: state_d = INIT;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q     <= INIT;
         ptr_q       <= '0;
         cur_q       <= '0;
         ich_q       <= '0;
         ireg_q      <= '0;
         ch_sel_q    <= '0;
         rd_en_q     <= '0;
         busy_q      <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_q       <= cur_d;
         ich_q       <= ich_d;
         ireg_q      <= ireg_d;
         ch_sel_q    <= ch_sel_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         init_done_q <= init_done_d;
      end
   spi_reg_writer #(.RST_ADR(ADR_DIVIDE), .RST_DAT(DIVIDE_VAL)) u_wr (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .adr_i    (req_adr),
      .dat_i    (req_dat),
      .adr      (adr),
      .cmd_word (cmd_word),
      .cmd_stb  (cmd_stb),
      .done     (done)
   );
   assign rd_en     = rd_en_q;
   assign ch_sel    = ch_sel_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;
endmodule
